// File: rtl/cave_pkg.sv
// Shared definitions for the ROM download path into DDR.
package cave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DDR_BEAT_BYTES = 8;
    localparam int LANES          = 4;

    // Byte-enable pair for one 16-bit lane of a 64-bit beat.
    function automatic logic [7:0] lane_mask(input logic [1:0] lane);
        return 8'b0000_0011 << {lane, 1'b0};
    endfunction

endpackage

// File: rtl/ioctl_ddr_writer.sv
// Packs the 16-bit ioctl download stream into 64-bit single-beat DDR writes
// with byte masks, stalling hps_io while a beat is in flight.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no line held
// ST_FILL  | line open, merging words into it
// ST_FLUSH | ddr_wr high, beat held stable until DDR accepts it
// ST_DONE  | one-cycle done pulse after the final flush
module ioctl_ddr_writer
    import cave_pkg::*;
#(
    parameter logic [7:0]  INDEX     = 8'd0,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        ddr_wr,
    output logic [31:0] ddr_addr,
    output logic [63:0] ddr_din,
    output logic [7:0]  ddr_mask,
    output logic [7:0]  ddr_burstCount,
    input  logic        ddr_waitReq,
    output logic        done
);

    state_e      state_q, state_d;
    logic [23:0] line_q, line_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] din_q, din_d;
    logic [7:0]  mask_q, mask_d;
    logic        pend_valid_q, pend_valid_d;
    logic [23:0] pend_line_q, pend_line_d;
    logic [1:0]  pend_lane_q, pend_lane_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic        end_q, end_d;
    logic        dl_prev_q;

    logic        acc, fall, ddr_acc;
    logic [23:0] wr_line;
    logic [1:0]  wr_lane;
    logic [7:0]  merged_mask;

    always_comb begin
        acc         = ioctl_download & ioctl_wr & (ioctl_index == INDEX);
        fall        = dl_prev_q & ~ioctl_download;
        ddr_acc     = (state_q == ST_FLUSH) & ~ddr_waitReq;
        wr_line     = ioctl_addr[26:3];
        wr_lane     = ioctl_addr[2:1];
        merged_mask = mask_q | lane_mask(wr_lane);
    end

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        addr_d       = addr_q;
        din_d        = din_q;
        mask_d       = mask_q;
        pend_valid_d = pend_valid_q;
        pend_line_d  = pend_line_q;
        pend_lane_d  = pend_lane_q;
        pend_data_d  = pend_data_q;
        end_d        = end_q;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    line_d                 = wr_line;
                    addr_d                 = BASE_ADDR + {5'd0, wr_line, 3'b000};
                    din_d                  = '0;
                    din_d[wr_lane*16 +: 16] = ioctl_dout;
                    mask_d                 = lane_mask(wr_lane);
                    state_d                = ST_FILL;
                end else if (fall) begin
                    state_d = ST_DONE;
                end
            end
            ST_FILL: begin
                if (acc && wr_line == line_q) begin
                    din_d[wr_lane*16 +: 16] = ioctl_dout;
                    mask_d                 = merged_mask;
                    if (merged_mask == 8'hFF) state_d = ST_FLUSH;
                end else if (acc) begin
                    pend_valid_d = 1'b1;
                    pend_line_d  = wr_line;
                    pend_lane_d  = wr_lane;
                    pend_data_d  = ioctl_dout;
                    state_d      = ST_FLUSH;
                end else if (fall) begin
                    end_d   = 1'b1;
                    state_d = ST_FLUSH;
                end else if (end_q) begin
                    // Line reopened from a pending word after download already ended.
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fall) end_d = 1'b1;
                if (ddr_acc && pend_valid_q) begin
                    line_d                     = pend_line_q;
                    addr_d                     = BASE_ADDR + {5'd0, pend_line_q, 3'b000};
                    din_d                      = '0;
                    din_d[pend_lane_q*16 +: 16] = pend_data_q;
                    mask_d                     = lane_mask(pend_lane_q);
                    pend_valid_d               = 1'b0;
                    state_d                    = ST_FILL;
                end else if (ddr_acc && acc) begin
                    line_d                 = wr_line;
                    addr_d                 = BASE_ADDR + {5'd0, wr_line, 3'b000};
                    din_d                  = '0;
                    din_d[wr_lane*16 +: 16] = ioctl_dout;
                    mask_d                 = lane_mask(wr_lane);
                    state_d                = ST_FILL;
                end else if (ddr_acc) begin
                    din_d   = '0;
                    mask_d  = '0;
                    state_d = end_d ? ST_DONE : ST_IDLE;
                end
                if (acc && !(ddr_acc && !pend_valid_q)) begin
                    pend_valid_d = 1'b1;
                    pend_line_d  = wr_line;
                    pend_lane_d  = wr_lane;
                    pend_data_d  = ioctl_dout;
                end
            end
            ST_DONE: begin
                end_d = 1'b0;
                if (acc) begin
                    line_d                 = wr_line;
                    addr_d                 = BASE_ADDR + {5'd0, wr_line, 3'b000};
                    din_d                  = '0;
                    din_d[wr_lane*16 +: 16] = ioctl_dout;
                    mask_d                 = lane_mask(wr_lane);
                    state_d                = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            line_q       <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            mask_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_line_q  <= '0;
            pend_lane_q  <= '0;
            pend_data_q  <= '0;
            end_q        <= 1'b0;
            dl_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            mask_q       <= mask_d;
            pend_valid_q <= pend_valid_d;
            pend_line_q  <= pend_line_d;
            pend_lane_q  <= pend_lane_d;
            pend_data_q  <= pend_data_d;
            end_q        <= end_d;
            dl_prev_q    <= ioctl_download;
        end
    end

    assign ioctl_wait     = (state_q == ST_FLUSH) | pend_valid_q;
    assign ddr_wr         = (state_q == ST_FLUSH);
    assign ddr_addr       = addr_q;
    assign ddr_din        = din_q;
    assign ddr_mask       = mask_q;
    assign ddr_burstCount = 8'd1;
    assign done           = (state_q == ST_DONE);

endmodule
